// File: rtl/pipe_ctrl_chain_if.sv
// Handshake/bus bundle between the decoder, the control-word chain and the datapath stage muxes.
interface pipe_ctrl_chain_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
);
    logic [WIDTH-1:0]        new_word;
    logic                    new_valid;
    logic [STAGES-1:0]       flush;
    logic [STAGES-1:0]       hold;
    logic                    i_resp;
    logic                    d_resp;
    logic [STAGES*WIDTH-1:0] stage_word;
    logic [STAGES-1:0]       stage_valid;
    logic                    stall;

    modport master (
        output new_word, new_valid, flush, hold, i_resp, d_resp,
        input  stage_word, stage_valid, stall
    );

    modport slave (
        input  new_word, new_valid, flush, hold, i_resp, d_resp,
        output stage_word, stage_valid, stall
    );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// Parametrised control-word pipeline chain with flush, hazard hold/bubble and cache stall.
// Define PIPE_CTRL_PERF_EN to add saturating stall/hold/flush performance counters.
module pipe_ctrl_chain #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     STAGES    = 4,
    parameter int unsigned     MEM_STAGE = 2,
    parameter int unsigned     RD_BIT    = 0,
    parameter int unsigned     WR_BIT    = 1,
    parameter logic [WIDTH-1:0] BUBBLE   = '0
) (
    input  logic               clk,
    input  logic               rst,
    pipe_ctrl_chain_if.slave   bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        hold_cycles,
    output logic [31:0]        flush_count
`endif
);

    logic [WIDTH-1:0]  word_q   [STAGES];
    logic [WIDTH-1:0]  word_d   [STAGES];
    logic [WIDTH-1:0]  src_word [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] keep;
    logic [STAGES-1:0] bubble;
    logic              hold_acc;
    logic              d_seen_q;
    logic              d_seen_d;
    logic [WIDTH-1:0]  mem_word;
    logic              d_req;
    logic              d_done;
    logic              stall_c;

    // Data-cache request comes from the word sitting in the memory stage
    assign mem_word = word_q[MEM_STAGE];
    assign d_req    = valid_q[MEM_STAGE] & (mem_word[RD_BIT] | mem_word[WR_BIT]);
    assign d_done   = bus.d_resp | d_seen_q;
    assign stall_c  = ~bus.i_resp | (d_req & ~d_done);

    // An early data response is remembered until the I-cache catches up
    always_comb begin
        d_seen_d = 1'b0;
        if (stall_c) begin
            d_seen_d = d_seen_q | (bus.d_resp & d_req);
        end
    end

    // keep[k]: some hold bit at index >= k; bubble goes just below the highest hold
    always_comb begin
        keep     = '0;
        bubble   = '0;
        hold_acc = 1'b0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            hold_acc = hold_acc | bus.hold[k];
            keep[k]  = hold_acc;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            bubble[k] = keep[k-1] & ~keep[k];
        end
    end

    // Next contents per stage: flush wins over hold, bubble and advance
    always_comb begin
        src_word[0]  = bus.new_word;
        src_valid[0] = bus.new_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_word[k]  = word_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
        valid_d = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            word_d[k]  = src_word[k];
            valid_d[k] = src_valid[k];
            if (keep[k]) begin
                word_d[k]  = word_q[k];
                valid_d[k] = valid_q[k];
            end else if (bubble[k]) begin
                word_d[k]  = BUBBLE;
                valid_d[k] = 1'b0;
            end
            if (bus.flush[k]) begin
                word_d[k]  = BUBBLE;
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                word_q[k] <= BUBBLE;
            end
            valid_q  <= '0;
            d_seen_q <= 1'b0;
        end else begin
            d_seen_q <= d_seen_d;
            if (!stall_c) begin
                for (int k = 0; k < int'(STAGES); k++) begin
                    word_q[k] <= word_d[k];
                end
                valid_q <= valid_d;
            end
        end
    end

    for (genvar g = 0; g < int'(STAGES); g++) begin : g_out
        assign bus.stage_word[g*WIDTH +: WIDTH] = word_q[g];
    end
    assign bus.stage_valid = valid_q;
    assign bus.stall       = stall_c;

`ifdef PIPE_CTRL_PERF_EN
    localparam int unsigned HIT_W = $clog2(STAGES + 1);

    logic [HIT_W-1:0] flush_hits;
    logic [32:0]      flush_sum;

    always_comb begin
        flush_hits = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            flush_hits = flush_hits + HIT_W'(bus.flush[k] & valid_q[k]);
        end
        flush_sum = {1'b0, flush_count} + 33'(flush_hits);
    end

    // Saturating counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            hold_cycles  <= '0;
            flush_count  <= '0;
        end else if (stall_c) begin
            if (stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end else begin
            if ((|bus.hold) && (hold_cycles != 32'hFFFF_FFFF)) begin
                hold_cycles <= hold_cycles + 32'd1;
            end
            flush_count <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed table-driven bench for pipe_ctrl_chain (WIDTH=32, STAGES=4, MEM_STAGE=2).
module tb_pipe_ctrl_chain;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_ctrl_chain_if #(.WIDTH(W), .STAGES(S)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, hold_cycles, flush_count;
`endif

    pipe_ctrl_chain #(
        .WIDTH(W), .STAGES(S), .MEM_STAGE(2), .RD_BIT(0), .WR_BIT(1), .BUBBLE('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .hold_cycles  (hold_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] nw;
        logic        nv;
        logic [3:0]  fl;
        logic [3:0]  hd;
        logic        ir;
        logic        dr;
        logic        st;
        logic [31:0] w0, w1, w2, w3;
        logic [3:0]  v;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [31:0] nw, input logic nv, input logic [3:0] fl,
                                input logic [3:0] hd, input logic ir, input logic dr, input logic st,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3, input logic [3:0] v);
        vec_t r;
        r.nw = nw; r.nv = nv; r.fl = fl; r.hd = hd; r.ir = ir; r.dr = dr; r.st = st;
        r.w0 = w0; r.w1 = w1; r.w2 = w2; r.w3 = w3; r.v = v;
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] nw, input logic nv, input logic [3:0] fl,
                         input logic [3:0] hd, input logic ir, input logic dr);
        bus.new_word  = nw;
        bus.new_valid = nv;
        bus.flush     = fl;
        bus.hold      = hd;
        bus.i_resp    = ir;
        bus.d_resp    = dr;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(32'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

        // free run
        add(32'h110, 1, 4'h0, 4'h0, 1, 0, 0, 32'h110, 32'h0,   32'h0,   32'h0,   4'b0001);
        add(32'h220, 1, 4'h0, 4'h0, 1, 0, 0, 32'h220, 32'h110, 32'h0,   32'h0,   4'b0011);
        add(32'h330, 1, 4'h0, 4'h0, 1, 0, 0, 32'h330, 32'h220, 32'h110, 32'h0,   4'b0111);
        add(32'h440, 1, 4'h0, 4'h0, 1, 0, 0, 32'h440, 32'h330, 32'h220, 32'h110, 4'b1111);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h440, 32'h330, 32'h220, 4'b1110);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h440, 32'h330, 4'b1100);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h440, 4'b1000);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,   4'b0000);
        // hold and bubble
        add(32'hC0,  1, 4'h0, 4'h0, 1, 0, 0, 32'hC0,  32'h0,   32'h0,   32'h0,   4'b0001);
        add(32'hB0,  1, 4'h0, 4'h0, 1, 0, 0, 32'hB0,  32'hC0,  32'h0,   32'h0,   4'b0011);
        add(32'hA0,  1, 4'h0, 4'h0, 1, 0, 0, 32'hA0,  32'hB0,  32'hC0,  32'h0,   4'b0111);
        add(32'hD0,  1, 4'h0, 4'b0010, 1, 0, 0, 32'hA0, 32'hB0, 32'h0,  32'hC0,  4'b1011);
        add(32'hD0,  1, 4'h0, 4'h0, 1, 0, 0, 32'hD0,  32'hA0,  32'hB0,  32'h0,   4'b0111);
        // flush over hold
        add(32'hE0,  1, 4'b0011, 4'b0001, 1, 0, 0, 32'h0, 32'h0, 32'hA0, 32'hB0, 4'b1100);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'hA0,  4'b1000);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,   4'b0000);
        // data wait: load in stage 2 stalls three cycles, flush/hold ignored while stalled
        add(32'h501, 1, 4'h0, 4'h0, 1, 0, 0, 32'h501, 32'h0,   32'h0,   32'h0,   4'b0001);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h501, 32'h0,   32'h0,   4'b0010);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h501, 32'h0,   4'b0100);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 1, 32'h0,   32'h0,   32'h501, 32'h0,   4'b0100);
        add(32'h77,  1, 4'hF, 4'b0010, 1, 0, 1, 32'h0, 32'h0,  32'h501, 32'h0,   4'b0100);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 1, 32'h0,   32'h0,   32'h501, 32'h0,   4'b0100);
        add(32'h0,   0, 4'h0, 4'h0, 1, 1, 0, 32'h0,   32'h0,   32'h0,   32'h501, 4'b1000);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,   4'b0000);
        // early data response during I-cache miss
        add(32'h601, 1, 4'h0, 4'h0, 1, 0, 0, 32'h601, 32'h0,   32'h0,   32'h0,   4'b0001);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h601, 32'h0,   32'h0,   4'b0010);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h601, 32'h0,   4'b0100);
        add(32'h0,   0, 4'h0, 4'h0, 0, 1, 1, 32'h0,   32'h0,   32'h601, 32'h0,   4'b0100);
        add(32'h0,   0, 4'h0, 4'h0, 0, 0, 1, 32'h0,   32'h0,   32'h601, 32'h0,   4'b0100);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h601, 4'b1000);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,   4'b0000);
        // I-cache miss alone; d_resp without a request
        add(32'h0,   0, 4'h0, 4'h0, 0, 1, 1, 32'h0,   32'h0,   32'h0,   32'h0,   4'b0000);
        add(32'h0,   0, 4'h0, 4'h0, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,   4'b0000);
        // top hold bit freezes whole chain without bubble; later-stage flush
        add(32'h110, 1, 4'h0, 4'h0, 1, 0, 0, 32'h110, 32'h0,   32'h0,   32'h0,   4'b0001);
        add(32'h220, 1, 4'h0, 4'b1000, 1, 0, 0, 32'h110, 32'h0, 32'h0,  32'h0,   4'b0001);
        add(32'h220, 1, 4'h0, 4'h0, 1, 0, 0, 32'h220, 32'h110, 32'h0,   32'h0,   4'b0011);
        add(32'h330, 1, 4'b0100, 4'h0, 1, 0, 0, 32'h330, 32'h220, 32'h0, 32'h0,  4'b0011);

        #1;
        check("reset_word",  128'(bus.stage_word),  128'h0);
        check("reset_valid", 128'(bus.stage_valid), 128'h0);
        check("reset_stall", 128'(bus.stall),       128'h0);

        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].nw, vecs[i].nv, vecs[i].fl, vecs[i].hd, vecs[i].ir, vecs[i].dr);
            #1;
            check($sformatf("row%0d_stall", i), 128'(bus.stall), 128'(vecs[i].st));
            @(posedge clk);
            #1;
            check($sformatf("row%0d_word", i), 128'(bus.stage_word),
                  {vecs[i].w3, vecs[i].w2, vecs[i].w1, vecs[i].w0});
            check($sformatf("row%0d_valid", i), 128'(bus.stage_valid), 128'(vecs[i].v));
            @(negedge clk);
        end

        // async reset while stalled with an early data response latched
        drive(32'h501, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(32'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        #1;
        check("pre_rst_valid",  128'(bus.stage_valid), 128'b1100);
        check("pre_rst_stall",  128'(bus.stall),       128'h1);
        check("pre_rst_d_seen", 128'(dut.d_seen_q),    128'h1);
        #1;
        rst         = 1'b0;
        bus.i_resp  = 1'b1;
        #1;
        check("arst_word",   128'(bus.stage_word),  128'h0);
        check("arst_valid",  128'(bus.stage_valid), 128'h0);
        check("arst_d_seen", 128'(dut.d_seen_q),    128'h0);
        check("arst_stall",  128'(bus.stall),       128'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(32'h330, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst_word",  128'(bus.stage_word),  128'h330);
        check("post_rst_valid", 128'(bus.stage_valid), 128'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
